// File: rtl/vid_line_composer.sv
// rtl/vid_line_composer.sv - per-line pixel source: background with one overlaid window
// Optional 8x8 checker inside the window when built with VID_LINE_CHECKER_EN.
module vid_line_composer #(
  parameter int H_ACTIVE = 640,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iLINE_REQ,
  input  logic [YW-1:0] iLINE_Y,
  input  logic [14:0]   iBG_RGB,
  input  logic [14:0]   iFG_RGB,
  input  logic [XW-1:0] iWIN_X0,
  input  logic [XW-1:0] iWIN_X1,
  input  logic [YW-1:0] iWIN_Y0,
  input  logic [YW-1:0] iWIN_Y1,
  input  logic          iCHECK_ON,
  input  logic          iPIX_FULL,
  output logic          oPIX_START,
  output logic          oPIX_WRITE,
  output logic [14:0]   oPIX_RGB,
  output logic          oBUSY,
  output logic          oLINE_DONE
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] s_y, s_y0, s_y1;
  logic [XW-1:0] s_x0, s_x1;
  logic [14:0]   s_bg, s_fg;
  logic          in_win, use_fg, last_px, wr;
  logic [14:0]   pix;

  assign wr      = (state == S_RUN) && !iPIX_FULL;
  assign last_px = (x == XW'(H_ACTIVE - 1));

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (iLINE_REQ) state_nx = S_START;
      S_START: state_nx = S_RUN;
      S_RUN:   if (wr && last_px) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    oPIX_START = (state == S_START);
    oPIX_WRITE = wr;
    oBUSY      = (state != S_IDLE);
    oLINE_DONE = (state == S_DONE);
    oPIX_RGB   = (state == S_RUN) ? pix : 15'd0;
  end

  // Shadow copies make the line immune to config changes after the request.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      x    <= '0;
      s_y  <= '0;
      s_y0 <= '0;
      s_y1 <= '0;
      s_x0 <= '0;
      s_x1 <= '0;
      s_bg <= '0;
      s_fg <= '0;
    end else begin
      if (state == S_IDLE && iLINE_REQ) begin
        s_y  <= iLINE_Y;
        s_y0 <= iWIN_Y0;
        s_y1 <= iWIN_Y1;
        s_x0 <= iWIN_X0;
        s_x1 <= iWIN_X1;
        s_bg <= iBG_RGB;
        s_fg <= iFG_RGB;
      end
      if (state == S_START)  x <= '0;
      else if (wr)           x <= x + 1'b1;
    end
  end

  assign in_win = (x >= s_x0) && (x <= s_x1) && (s_y >= s_y0) && (s_y <= s_y1);

`ifdef VID_LINE_CHECKER_EN
  logic s_chk;

  always_ff @(posedge iCLK) begin
    if (iRESET)                            s_chk <= 1'b0;
    else if (state == S_IDLE && iLINE_REQ) s_chk <= iCHECK_ON;
  end

  assign use_fg = in_win && !(s_chk && (x[3] ^ s_y[3]));
`else
  logic unused_check_on;

  assign unused_check_on = iCHECK_ON;
  assign use_fg          = in_win;
`endif

  assign pix = use_fg ? s_fg : s_bg;

endmodule
